// File: rtl/jtag_tap_ir_if.sv
// JTAG TAP/IR signal bundle: TMS/TDI in, IR serial out, latched instruction and state decodes out.
// No latency and no backpressure of its own; master drives TMS/TDI, slave is the TAP.
interface jtag_tap_ir_if #(
  parameter int IR_WIDTH = 4
);
  logic                TMS;
  logic                TDI;
  logic                IR_TDO;
  logic                IR_TDO_EN;
  logic [IR_WIDTH-1:0] LATCH_JTAG_IR;
  logic [3:0]          TAP_STATE;
  logic                TLR_STATE;
  logic                RTI_STATE;
  logic                CAPTURE_DR;
  logic                SHIFT_DR;
  logic                UPDATE_DR;

  modport master (
    output TMS, TDI,
    input  IR_TDO, IR_TDO_EN, LATCH_JTAG_IR, TAP_STATE,
    input  TLR_STATE, RTI_STATE, CAPTURE_DR, SHIFT_DR, UPDATE_DR
  );

  modport slave (
    input  TMS, TDI,
    output IR_TDO, IR_TDO_EN, LATCH_JTAG_IR, TAP_STATE,
    output TLR_STATE, RTI_STATE, CAPTURE_DR, SHIFT_DR, UPDATE_DR
  );
endinterface

// File: rtl/jtag_tap_ir.sv
// IEEE 1149.1 TAP FSM with 4-bit IR; one TCK edge per state step, outputs decode the registered state.
// No backpressure: TMS/TDI are consumed on every rising TCK edge.
module jtag_tap_ir #(
  parameter int                  IR_WIDTH   = 4,
  parameter logic [IR_WIDTH-1:0] IR_CAPTURE = IR_WIDTH'(4'b0001),
  parameter logic [IR_WIDTH-1:0] IR_RESET   = IR_WIDTH'(4'h7)
) (
  input logic          TCK,
  input logic          RST,
  jtag_tap_ir_if.slave bus
);

  typedef enum logic [3:0] {
    TLR    = 4'h0, RTI    = 4'h1, SEL_DR = 4'h2, CAP_DR = 4'h3,
    SH_DR  = 4'h4, EX1_DR = 4'h5, PA_DR  = 4'h6, EX2_DR = 4'h7,
    UP_DR  = 4'h8, SEL_IR = 4'h9, CAP_IR = 4'hA, SH_IR  = 4'hB,
    EX1_IR = 4'hC, PA_IR  = 4'hD, EX2_IR = 4'hE, UP_IR  = 4'hF
  } tap_state_t;

  tap_state_t          state_q;
  tap_state_t          state_d;
  logic [IR_WIDTH-1:0] ir_sr;
  logic [IR_WIDTH-1:0] latch_q;

  always_ff @(posedge TCK) begin
    if (RST) state_q <= TLR;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      TLR:    state_d = bus.TMS ? TLR    : RTI;
      RTI:    state_d = bus.TMS ? SEL_DR : RTI;
      SEL_DR: state_d = bus.TMS ? SEL_IR : CAP_DR;
      CAP_DR: state_d = bus.TMS ? EX1_DR : SH_DR;
      SH_DR:  state_d = bus.TMS ? EX1_DR : SH_DR;
      EX1_DR: state_d = bus.TMS ? UP_DR  : PA_DR;
      PA_DR:  state_d = bus.TMS ? EX2_DR : PA_DR;
      EX2_DR: state_d = bus.TMS ? UP_DR  : SH_DR;
      UP_DR:  state_d = bus.TMS ? SEL_DR : RTI;
      SEL_IR: state_d = bus.TMS ? TLR    : CAP_IR;
      CAP_IR: state_d = bus.TMS ? EX1_IR : SH_IR;
      SH_IR:  state_d = bus.TMS ? EX1_IR : SH_IR;
      EX1_IR: state_d = bus.TMS ? UP_IR  : PA_IR;
      PA_IR:  state_d = bus.TMS ? EX2_IR : PA_IR;
      EX2_IR: state_d = bus.TMS ? UP_IR  : SH_IR;
      UP_IR:  state_d = bus.TMS ? SEL_DR : RTI;
      default: state_d = TLR;
    endcase
  end

  // The shift on the SH_IR exit edge still consumes TDI, since it keys off the current state only.
  always_ff @(posedge TCK) begin
    if (RST) begin
      ir_sr <= IR_CAPTURE;
    end else if (state_q == CAP_IR) begin
      ir_sr <= IR_CAPTURE;
    end else if (state_q == SH_IR) begin
      ir_sr <= {bus.TDI, ir_sr[IR_WIDTH-1:1]};
    end
  end

  always_ff @(posedge TCK) begin
    if (RST || state_q == TLR) begin
      latch_q <= IR_RESET;
    end else if (state_q == UP_IR) begin
      latch_q <= ir_sr;
    end
  end

  assign bus.IR_TDO        = ir_sr[0];
  assign bus.IR_TDO_EN     = (state_q == SH_IR);
  assign bus.LATCH_JTAG_IR = latch_q;
  assign bus.TAP_STATE     = state_q;
  assign bus.TLR_STATE     = (state_q == TLR);
  assign bus.RTI_STATE     = (state_q == RTI);
  assign bus.CAPTURE_DR    = (state_q == CAP_DR);
  assign bus.SHIFT_DR      = (state_q == SH_DR);
  assign bus.UPDATE_DR     = (state_q == UP_DR);

endmodule
